// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit: branch mode codes,
// 2-bit predictor counter states and small saturating-update helpers.
package branch_pkg;

    localparam logic [5:0] MODE_BRZ    = 6'b101000;
    localparam logic [5:0] MODE_BNE    = 6'b101001;
    localparam logic [5:0] MODE_BSR2   = 6'b101010;
    localparam logic [5:0] MODE_BSR0   = 6'b101011;
    localparam logic [5:0] MODE_BSR1   = 6'b101100;
    localparam logic [5:0] MODE_BALW   = 6'b101101;
    localparam logic [5:0] MODE_BEQ    = 6'b101110;
    localparam logic [5:0] MODE_BLT    = 6'b101111;

    localparam logic [15:0] CNT_MAX    = 16'hFFFF;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

    // All eight codes of the 101xxx group are branches.
    function automatic logic is_branch(input logic [5:0] mode);
        return (mode[5:3] == 3'b101);
    endfunction

    function automatic bht_state_e bht_inc(input bht_state_e s);
        bht_state_e r;
        case (s)
            SNT:     r = WNT;
            WNT:     r = WT;
            WT:      r = ST;
            default: r = ST;
        endcase
        return r;
    endfunction

    function automatic bht_state_e bht_dec(input bht_state_e s);
        bht_state_e r;
        case (s)
            ST:      r = WT;
            WT:      r = WNT;
            WNT:     r = SNT;
            default: r = SNT;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: decides whether a mode code
// is a branch and, if so, whether it is taken.
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [3:0]        sr_i,
    input  logic [5:0]        mode_i,
    output logic              is_branch_o,
    output logic              taken_o
);

    logic unused_sr;
    assign unused_sr = sr_i[3];

    always_comb begin
        is_branch_o = is_branch(mode_i);
        taken_o     = 1'b0;
        case (mode_i)
            MODE_BRZ:  taken_o = (reg1_i == '0);
            MODE_BNE:  taken_o = (reg1_i != reg2_i);
            MODE_BSR2: taken_o = sr_i[2];
            MODE_BSR0: taken_o = sr_i[0];
            MODE_BSR1: taken_o = sr_i[1];
            MODE_BALW: taken_o = 1'b1;
            MODE_BEQ:  taken_o = (reg1_i == reg2_i);
            MODE_BLT:  taken_o = ($signed(reg1_i) < $signed(reg2_i));
            default:   taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve stage: evaluates the branch condition, registers the
// resolved result, trains a 2-bit BHT and keeps branch statistics.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int PC_W      = 16,
    parameter int BHT_DEPTH = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic              i_stall,
    input  logic              i_kill,
    input  logic [PC_W-1:0]   i_pc,
    input  logic [PC_W-1:0]   i_target,
    input  logic              i_pred_taken,
    input  logic [DATA_W-1:0] i_reg1,
    input  logic [DATA_W-1:0] i_reg2,
    input  logic [3:0]        i_SR,
    input  logic [5:0]        i_ALUmode,
    input  logic [PC_W-1:0]   i_lookup_pc,
    output logic              o_lookup_taken,
    output logic              o_valid,
    output logic              o_taken,
    output logic              o_mispredict,
    output logic [PC_W-1:0]   o_redirect_pc,
    output logic [15:0]       o_branch_cnt,
    output logic [15:0]       o_mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic             isBranch;
    logic             condTaken;
    logic             accept;
    logic             mispredict;
    logic [IDX_W-1:0] pcIdx;
    logic [IDX_W-1:0] lookupIdx;
    logic [PC_W-1:0]  redirect_d;
    bht_state_e       bhtEntry_d;

    bht_state_e       bht_q [BHT_DEPTH];
    logic             valid_q;
    logic             taken_q;
    logic             mispredict_q;
    logic [PC_W-1:0]  redirect_q;
    logic [15:0]      branchCnt_q;
    logic [15:0]      mispredCnt_q;

    logic unused_lookup;
    assign unused_lookup = ^i_lookup_pc[PC_W-1:IDX_W];

    branch_cond_eval #(
        .DATA_W (DATA_W)
    ) u_cond_eval (
        .reg1_i      (i_reg1),
        .reg2_i      (i_reg2),
        .sr_i        (i_SR),
        .mode_i      (i_ALUmode),
        .is_branch_o (isBranch),
        .taken_o     (condTaken)
    );

    // Kill dominates stall, stall dominates valid.
    assign accept     = i_valid & ~i_kill & ~i_stall & isBranch;
    assign mispredict = condTaken ^ i_pred_taken;
    assign pcIdx      = i_pc[IDX_W-1:0];
    assign lookupIdx  = i_lookup_pc[IDX_W-1:0];

    always_comb begin
        redirect_d = condTaken ? i_target : i_pc + PC_W'(1);
        bhtEntry_d = condTaken ? bht_inc(bht_q[pcIdx]) : bht_dec(bht_q[pcIdx]);
    end

    // Lookup reads the registered table, so a same-cycle update is not visible yet.
    assign o_lookup_taken = bht_q[lookupIdx][1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= WNT;
            end
        end else if (accept) begin
            bht_q[pcIdx] <= bhtEntry_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q      <= 1'b0;
            taken_q      <= 1'b0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
        end else begin
            valid_q <= accept;
            if (accept) begin
                taken_q      <= condTaken;
                mispredict_q <= mispredict;
                redirect_q   <= redirect_d;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            branchCnt_q  <= '0;
            mispredCnt_q <= '0;
        end else if (accept) begin
            branchCnt_q <= sat_inc16(branchCnt_q);
            if (mispredict) begin
                mispredCnt_q <= sat_inc16(mispredCnt_q);
            end
        end
    end

    assign o_valid       = valid_q;
    assign o_taken       = taken_q;
    assign o_mispredict  = mispredict_q;
    assign o_redirect_pc = redirect_q;
    assign o_branch_cnt  = branchCnt_q;
    assign o_mispred_cnt = mispredCnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit with hand-computed
// expected values checked by immediate assertions.
module tb_branch_resolve_unit;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        i_stall;
    logic        i_kill;
    logic [15:0] i_pc;
    logic [15:0] i_target;
    logic        i_pred_taken;
    logic [15:0] i_reg1;
    logic [15:0] i_reg2;
    logic [3:0]  i_SR;
    logic [5:0]  i_ALUmode;
    logic [15:0] i_lookup_pc;
    logic        o_lookup_taken;
    logic        o_valid;
    logic        o_taken;
    logic        o_mispredict;
    logic [15:0] o_redirect_pc;
    logic [15:0] o_branch_cnt;
    logic [15:0] o_mispred_cnt;

    int assertCount = 0;
    int failCount   = 0;

    branch_resolve_unit dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_valid        (i_valid),
        .i_stall        (i_stall),
        .i_kill         (i_kill),
        .i_pc           (i_pc),
        .i_target       (i_target),
        .i_pred_taken   (i_pred_taken),
        .i_reg1         (i_reg1),
        .i_reg2         (i_reg2),
        .i_SR           (i_SR),
        .i_ALUmode      (i_ALUmode),
        .i_lookup_pc    (i_lookup_pc),
        .o_lookup_taken (o_lookup_taken),
        .o_valid        (o_valid),
        .o_taken        (o_taken),
        .o_mispredict   (o_mispredict),
        .o_redirect_pc  (o_redirect_pc),
        .o_branch_cnt   (o_branch_cnt),
        .o_mispred_cnt  (o_mispred_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
            $error("[TB] %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] mode, input logic [15:0] pc,
                                 input logic [15:0] target, input logic pred,
                                 input logic [15:0] r1, input logic [15:0] r2,
                                 input logic [3:0] sr);
        i_valid      = 1'b1;
        i_ALUmode    = mode;
        i_pc         = pc;
        i_target     = target;
        i_pred_taken = pred;
        i_reg1       = r1;
        i_reg2       = r2;
        i_SR         = sr;
    endtask

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_stall = 1'b0; i_kill = 1'b0;
        i_pc = '0; i_target = '0; i_pred_taken = 1'b0; i_reg1 = '0; i_reg2 = '0;
        i_SR = '0; i_ALUmode = '0; i_lookup_pc = 16'h0003;
        tick(); tick();
        checkOutput("rst_valid", 32'(o_valid), 32'h0);
        checkOutput("rst_redirect", 32'(o_redirect_pc), 32'h0);
        checkOutput("rst_bcnt", 32'(o_branch_cnt), 32'h0);
        checkOutput("rst_lookup3", 32'(o_lookup_taken), 32'h0);
        i_rst_n = 1'b1;
        tick();

        // beqz taken against not-taken prediction
        applyStimulus(6'b101000, 16'h0010, 16'h0040, 1'b0, 16'h0000, 16'h0000, 4'h0);
        tick();
        checkOutput("brz_valid", 32'(o_valid), 32'h1);
        checkOutput("brz_taken", 32'(o_taken), 32'h1);
        checkOutput("brz_mispred", 32'(o_mispredict), 32'h1);
        checkOutput("brz_redirect", 32'(o_redirect_pc), 32'h0040);
        checkOutput("brz_mcnt", 32'(o_mispred_cnt), 32'h1);
        checkOutput("brz_bcnt", 32'(o_branch_cnt), 32'h1);
        i_valid = 1'b0;
        tick();
        checkOutput("idle_valid", 32'(o_valid), 32'h0);
        checkOutput("idle_hold_taken", 32'(o_taken), 32'h1);

        // signed less-than
        applyStimulus(6'b101111, 16'h0020, 16'h0080, 1'b1, 16'hFFFF, 16'h0001, 4'h0);
        tick();
        checkOutput("blt_neg_taken", 32'(o_taken), 32'h1);
        checkOutput("blt_neg_mispred", 32'(o_mispredict), 32'h0);
        checkOutput("blt_neg_redirect", 32'(o_redirect_pc), 32'h0080);
        applyStimulus(6'b101111, 16'h0021, 16'h0080, 1'b1, 16'h0001, 16'hFFFF, 4'h0);
        tick();
        checkOutput("blt_pos_valid", 32'(o_valid), 32'h1);
        checkOutput("blt_pos_taken", 32'(o_taken), 32'h0);
        checkOutput("blt_pos_redirect", 32'(o_redirect_pc), 32'h0022);
        checkOutput("blt_bcnt", 32'(o_branch_cnt), 32'h3);
        checkOutput("blt_mcnt", 32'(o_mispred_cnt), 32'h2);
        i_valid = 1'b0;
        tick();

        // BHT training at index 3, then aliased decrement via 0x0013
        i_lookup_pc = 16'h0003;
        applyStimulus(6'b101101, 16'h0003, 16'h0100, 1'b0, 16'h0, 16'h0, 4'h0);
        #1;
        checkOutput("bht_pre_update", 32'(o_lookup_taken), 32'h0);
        tick();
        checkOutput("bht_after1", 32'(o_lookup_taken), 32'h1);
        i_pred_taken = 1'b1;
        tick();
        tick();
        i_lookup_pc = 16'h0013;
        #1;
        checkOutput("bht_sat_alias", 32'(o_lookup_taken), 32'h1);
        checkOutput("bht_bcnt", 32'(o_branch_cnt), 32'h6);
        checkOutput("bht_mcnt", 32'(o_mispred_cnt), 32'h3);
        applyStimulus(6'b101000, 16'h0013, 16'h0100, 1'b0, 16'h0005, 16'h0, 4'h0);
        tick();
        checkOutput("bht_dec1", 32'(o_lookup_taken), 32'h1);
        checkOutput("nt_redirect", 32'(o_redirect_pc), 32'h0014);
        tick();
        checkOutput("bht_dec2", 32'(o_lookup_taken), 32'h0);
        checkOutput("nt_mcnt", 32'(o_mispred_cnt), 32'h3);
        i_valid = 1'b0;
        tick();

        // stall holds for three cycles, then a single pulse
        applyStimulus(6'b101101, 16'h0030, 16'h0050, 1'b1, 16'h0, 16'h0, 4'h0);
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("stall_valid", 32'(o_valid), 32'h0);
        end
        checkOutput("stall_bcnt", 32'(o_branch_cnt), 32'h8);
        i_stall = 1'b0;
        tick();
        checkOutput("unstall_valid", 32'(o_valid), 32'h1);
        checkOutput("unstall_bcnt", 32'(o_branch_cnt), 32'h9);
        i_valid = 1'b0;
        tick();
        checkOutput("unstall_pulse_end", 32'(o_valid), 32'h0);

        // kill wins over stall and valid
        applyStimulus(6'b101101, 16'h0030, 16'h0060, 1'b0, 16'h0, 16'h0, 4'h0);
        i_kill = 1'b1;
        i_stall = 1'b1;
        tick();
        i_stall = 1'b0;
        tick();
        checkOutput("kill_valid", 32'(o_valid), 32'h0);
        checkOutput("kill_bcnt", 32'(o_branch_cnt), 32'h9);
        checkOutput("kill_mcnt", 32'(o_mispred_cnt), 32'h3);
        i_kill = 1'b0;

        // non-branch mode
        applyStimulus(6'b000111, 16'h0030, 16'h0060, 1'b0, 16'h0, 16'h0, 4'h0);
        tick();
        checkOutput("nonbr_valid", 32'(o_valid), 32'h0);
        checkOutput("nonbr_bcnt", 32'(o_branch_cnt), 32'h9);

        // PC wrap on not-taken
        applyStimulus(6'b101000, 16'hFFFF, 16'h0100, 1'b1, 16'h0001, 16'h0, 4'h0);
        tick();
        checkOutput("wrap_redirect", 32'(o_redirect_pc), 32'h0000);
        checkOutput("wrap_mispred", 32'(o_mispredict), 32'h1);
        checkOutput("wrap_mcnt", 32'(o_mispred_cnt), 32'h4);

        // remaining condition codes
        applyStimulus(6'b101001, 16'h0040, 16'h0100, 1'b0, 16'h0005, 16'h0005, 4'h0);
        tick();
        checkOutput("bne_equal", 32'(o_taken), 32'h0);
        applyStimulus(6'b101010, 16'h0040, 16'h0100, 1'b0, 16'h0, 16'h0, 4'b0100);
        tick();
        checkOutput("sr2_set", 32'(o_taken), 32'h1);
        applyStimulus(6'b101011, 16'h0040, 16'h0100, 1'b0, 16'h0, 16'h0, 4'b1110);
        tick();
        checkOutput("sr0_clear", 32'(o_taken), 32'h0);
        applyStimulus(6'b101100, 16'h0040, 16'h0100, 1'b0, 16'h0, 16'h0, 4'b0010);
        tick();
        checkOutput("sr1_set", 32'(o_taken), 32'h1);
        applyStimulus(6'b101110, 16'h0040, 16'h0100, 1'b0, 16'h1234, 16'h1235, 4'h0);
        tick();
        checkOutput("beq_differ", 32'(o_taken), 32'h0);

        // reset in the middle of a result cycle
        applyStimulus(6'b101101, 16'h0003, 16'h0077, 1'b0, 16'h0, 16'h0, 4'h0);
        tick();
        checkOutput("pre_rst_valid", 32'(o_valid), 32'h1);
        i_rst_n = 1'b0;
        i_lookup_pc = 16'h0003;
        #1;
        checkOutput("mid_rst_valid", 32'(o_valid), 32'h0);
        checkOutput("mid_rst_taken", 32'(o_taken), 32'h0);
        checkOutput("mid_rst_mispred", 32'(o_mispredict), 32'h0);
        checkOutput("mid_rst_redirect", 32'(o_redirect_pc), 32'h0);
        checkOutput("mid_rst_bcnt", 32'(o_branch_cnt), 32'h0);
        checkOutput("mid_rst_mcnt", 32'(o_mispred_cnt), 32'h0);
        checkOutput("mid_rst_lookup3", 32'(o_lookup_taken), 32'h0);
        tick();
        i_rst_n = 1'b1;
        tick();
        checkOutput("post_rst_valid", 32'(o_valid), 32'h1);
        checkOutput("post_rst_bcnt", 32'(o_branch_cnt), 32'h1);
        checkOutput("post_rst_lookup3", 32'(o_lookup_taken), 32'h1);
        i_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning operand width.
REQ-002 SHALL have parameter PC_W, default 16, meaning program-counter width.
REQ-003 SHALL have parameter BHT_DEPTH, default 16, meaning prediction-table entries (power of 2, >= 2); IDX_W = log2(BHT_DEPTH).
REQ-004 SHALL have ports: i_clk in 1, the single clock; i_rst_n in 1, asynchronous active-low reset.
REQ-005 SHALL have ports: i_valid in 1, branch candidate present; i_stall in 1, hold stage; i_kill in 1, squash current candidate.
REQ-006 SHALL have ports: i_pc in PC_W, branch PC; i_target in PC_W, taken target; i_pred_taken in 1, fetch-time prediction.
REQ-007 SHALL have ports: i_reg1, i_reg2 in DATA_W, operands; i_SR in 4, status flags; i_ALUmode in 6, operation code.
REQ-008 SHALL have ports: i_lookup_pc in PC_W, fetch PC; o_lookup_taken out 1, prediction for i_lookup_pc.
REQ-009 SHALL have ports: o_valid out 1, resolved result; o_taken out 1; o_mispredict out 1; o_redirect_pc out PC_W.
REQ-010 SHALL have ports: o_branch_cnt out 16, resolved branches; o_mispred_cnt out 16, mispredictions.

Function
REQ-011 SHALL evaluate taken per mode: 101000 reg1==0; 101001 reg1!=reg2; 101010 SR[2]; 101011 SR[0]; 101100 SR[1]; 101101 always; 101110 reg1==reg2 (new); 101111 signed reg1<reg2 (new).
REQ-012 SHALL treat any other i_ALUmode as non-branch: no result, no table update, no count.
REQ-013 SHALL accept a candidate at a rising edge when i_valid=1, i_stall=0, i_kill=0 and mode is a branch ("accept").
REQ-014 SHALL assert o_valid for exactly the one cycle after an accept (latency 1); o_valid=0 otherwise, including during stall.
REQ-015 SHALL register o_taken, o_mispredict = (taken != i_pred_taken), o_redirect_pc = taken ? i_target : i_pc+1 (mod 2^PC_W) at accept; hold previous values when no accept.
REQ-016 SHALL hold a table of BHT_DEPTH 2-bit saturating counters indexed by pc[IDX_W-1:0]; state >= 2'b10 predicts taken.
REQ-017 SHALL update the entry of i_pc at accept: +1 if taken (saturate 11), -1 if not (saturate 00).
REQ-018 SHALL drive o_lookup_taken combinationally from the table; same-cycle lookup of an entry being updated returns pre-update value.
REQ-019 SHALL increment o_branch_cnt at every accept, o_mispred_cnt at accepts with mispredict; both saturate at 16'hFFFF.
REQ-020 SHALL give i_kill priority over i_stall and i_valid: killed candidate produces no output, update or count.
REQ-021 SHALL treat two consecutive accepts to the same index as sequential read-modify-write (second sees first's update).

Reset
REQ-022 SHALL, while i_rst_n=0, asynchronously force o_valid, o_taken, o_mispredict to 0, o_redirect_pc to 0, both counters to 0, all table entries to 2'b01.
REQ-023 SHALL discard any in-flight result when reset asserts mid-operation; first accept after release yields o_valid one cycle later.

Structure
REQ-024 SHALL take mode codes, counter-state constants (SNT=00, WNT=01, WT=10, ST=11) and an is_branch function from shared package branch_pkg.
REQ-025 SHALL contain one combinational sub-module branch_cond_eval (DATA_W-parametrised) implementing REQ-011/REQ-012.

Verification
REQ-026 SHALL cover: after reset, mode 101000 reg1=0, pc=0x0010, target=0x0040, pred=0 -> next cycle o_valid=1, o_taken=1, o_mispredict=1, o_redirect_pc=0x0040, o_mispred_cnt=1.
REQ-027 SHALL cover: mode 101111 reg1=0xFFFF, reg2=0x0001 -> taken=1; reg1=0x0001, reg2=0xFFFF -> taken=0, redirect=pc+1.
REQ-028 SHALL cover: three taken accepts at pc=0x0003 -> o_lookup_taken(0x0003) 0 after reset, 1 after first, entry saturates at 11 after third; pc=0x0013 aliases (DEPTH 16).
REQ-029 SHALL cover: i_valid=1 with i_stall=1 for 3 cycles then release -> single o_valid pulse, o_branch_cnt +1; with i_kill=1 -> no pulse, counts unchanged.
REQ-030 SHALL cover: mode 000111 with i_valid=1 -> o_valid stays 0; pc=0xFFFF not-taken -> o_redirect_pc=0x0000.
REQ-031 SHALL cover: i_rst_n low mid-accept -> outputs zero immediately, table reads 01 everywhere.
